// File: rtl/demux_1x8_pkg.sv
// Shared sizing constants for the 1-to-8 demux tree.
package demux_1x8_pkg;
    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;
endpackage

// File: rtl/demux_1x8_tree_demux_1x2.sv
// Combinational 1-to-2 demux cell: d goes to y1 when s is set, else to y0.
module demux_1x2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);
    assign y0 = s ? '0 : d;
    assign y1 = s ? d : '0;
endmodule

// File: rtl/demux_1x8_tree.sv
// 1-to-8 demux built from three levels of demux_1x2, output registered on clk.
// Define DEMUX_1X8_COMB_OUT_EN to drop the output register (zero-latency build).
module demux_1x8_tree
    import demux_1x8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         i,
    input  logic [SEL_W-1:0]         sel,
    output logic [NUM_OUT*WIDTH-1:0] y
);
    logic [WIDTH-1:0]         w_l1 [2];
    logic [WIDTH-1:0]         w_l2 [4];
    logic [WIDTH-1:0]         w_l3 [NUM_OUT];
    logic [NUM_OUT*WIDTH-1:0] w_tree;

    demux_1x2 #(.WIDTH(WIDTH)) u_l1 (
        .d  (i),
        .s  (sel[2]),
        .y0 (w_l1[0]),
        .y1 (w_l1[1])
    );

    // Node j at each level feeds children 2j and 2j+1, so lane index equals sel.
    for (genvar j = 0; j < 2; j++) begin : g_l2
        demux_1x2 #(.WIDTH(WIDTH)) u_l2 (
            .d  (w_l1[j]),
            .s  (sel[1]),
            .y0 (w_l2[2*j]),
            .y1 (w_l2[2*j+1])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_l3
        demux_1x2 #(.WIDTH(WIDTH)) u_l3 (
            .d  (w_l2[j]),
            .s  (sel[0]),
            .y0 (w_l3[2*j]),
            .y1 (w_l3[2*j+1])
        );
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_pack
        assign w_tree[k*WIDTH +: WIDTH] = w_l3[k];
    end

`ifdef DEMUX_1X8_COMB_OUT_EN
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign y        = w_tree;
`else
    logic [NUM_OUT*WIDTH-1:0] r_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_tree;
        end
    end

    assign y = r_y;
`endif
endmodule

// File: tb/tb_demux_1x8_tree.sv
// Self-checking bench for demux_1x8_tree (WIDTH=1); covers both build options.
module tb_demux_1x8_tree;
    localparam int W = 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] i;
    logic [2:0]   sel;
    logic [7:0]   y;

    int checks   = 0;
    int failures = 0;

    demux_1x8_tree #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .sel   (sel),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lane sel carries the data, every other lane is zero.
    function automatic logic [7:0] model(input logic [W-1:0] din, input logic [2:0] s);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++)
            if (k == int'(s)) r[k] = din[0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef DEMUX_1X8_COMB_OUT_EN
    task automatic test_comb();
        rst_n = 1'b0;
        i = 1'b1; sel = 3'd7;
        #1;
        checks++;
        if (y !== 8'h80) begin
            failures++;
            $display("FAIL comb_sel7 got=%h exp=%h", y, 8'h80);
        end
        for (int n = 0; n < 20; n++) begin
            i   = W'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            #2;
            checks++;
            if (y !== model(i, sel)) begin
                failures++;
                $display("FAIL comb_rand sel=%0d i=%0d got=%h exp=%h", sel, i, y, model(i, sel));
            end
        end
    endtask
`else
    task automatic test_reset();
        rst_n = 1'b0; i = 1'b1; sel = 3'd5;
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (y !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=00", n, y);
            end
        end
    endtask

    task automatic test_sweep();
        rst_n = 1'b1; i = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            checks++;
            if (y !== (8'h01 << s)) begin
                failures++;
                $display("FAIL sweep sel=%0d got=%h exp=%h", s, y, 8'h01 << s);
            end
        end
    endtask

    task automatic test_zero_input();
        i = 1'b0; sel = 3'd6;
        step();
        checks++;
        if (y !== 8'h00) begin
            failures++;
            $display("FAIL zero_input got=%h exp=00", y);
        end
    endtask

    task automatic test_reset_mid();
        i = 1'b1; sel = 3'd3;
        step();
        checks++;
        if (y !== 8'h08) begin
            failures++;
            $display("FAIL mid_pre got=%h exp=08", y);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (y !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=00", y);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (y !== 8'h08) begin
            failures++;
            $display("FAIL mid_resume got=%h exp=08", y);
        end
    endtask

    task automatic test_random_onehot();
        logic [2:0] sel_prev;
        i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            sel = 3'($urandom_range(0, 7));
            sel_prev = sel;
            step();
            checks++;
            if (y !== (8'h01 << sel_prev) || !$onehot(y)) begin
                failures++;
                $display("FAIL rand_onehot n=%0d sel=%0d got=%h exp=%h", n, sel_prev, y, 8'h01 << sel_prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        for (int n = 0; n < 40; n++) begin
            i     = W'($urandom_range(0, 1));
            sel   = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 9) != 0);
            exp_q.push_back(rst_n ? model(i, sel) : 8'h00);
            step();
            exp = exp_q.pop_front();
            checks++;
            if (y !== exp) begin
                failures++;
                $display("FAIL b2b n=%0d got=%h exp=%h", n, y, exp);
            end
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; i = '0; sel = '0;
`ifdef DEMUX_1X8_COMB_OUT_EN
        test_comb();
`else
        test_reset();
        test_sweep();
        test_zero_input();
        test_reset_mid();
        test_random_onehot();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
